// File: rtl/ctrl_fetch_pkg.sv
// rtl/ctrl_fetch_pkg.sv - shared encodings and widths for the instruction-fetch control block
package ctrl_fetch_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    OFF_1   = 2'b00,
    OFF_2   = 2'b01,
    OFF_K12 = 2'b10,
    OFF_K16 = 2'b11
  } off_sel_e;

  typedef enum logic [1:0] {
    SRC_PC  = 2'b00,
    SRC_ABS = 2'b01,
    SRC_Z   = 2'b10,
    SRC_A   = 2'b11
  } src_sel_e;

  function automatic logic [WORD_W-1:0] sext12(input logic [11:0] k);
    return {{(WORD_W-12){k[11]}}, k};
  endfunction

endpackage

// File: rtl/ctrl_fetch_next_pc.sv
// rtl/ctrl_fetch_next_pc.sv - combinational offset select, PC adder and next-PC source mux
module ctrl_fetch_next_pc
  import ctrl_fetch_pkg::*;
(
  input  logic [1:0]        mode12k_i,
  input  logic [1:0]        mode_src_i,
  input  logic [WORD_W-1:0] pc_i,
  input  logic [WORD_W-1:0] k_i,
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] z_i,
  output logic [WORD_W-1:0] next_pc_o
);

  logic [WORD_W-1:0] offset;
  logic [WORD_W-1:0] pc_sum;

  always_comb begin
    offset = '0;
    case (off_sel_e'(mode12k_i))
      OFF_1:   offset = WORD_W'(1);
      OFF_2:   offset = WORD_W'(2);
      OFF_K12: offset = sext12(k_i[11:0]);
      OFF_K16: offset = k_i;
      default: offset = '0;
    endcase
  end

  // Modulo-2^16 add: the carry out is deliberately dropped.
  assign pc_sum = pc_i + offset;

  always_comb begin
    next_pc_o = '0;
    case (src_sel_e'(mode_src_i))
      SRC_PC:  next_pc_o = pc_sum;
      SRC_ABS: next_pc_o = offset;
      SRC_Z:   next_pc_o = z_i;
      SRC_A:   next_pc_o = a_i;
      default: next_pc_o = '0;
    endcase
  end

endmodule

// File: rtl/ctrl_fetch.sv
// rtl/ctrl_fetch.sv - PC and IR registers plus program-memory address/data drive
module ctrl_fetch
  import ctrl_fetch_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_mode12K,
  input  logic [1:0]  i_modeAddZA,
  input  logic        i_modePCZ,
  input  logic        i_loadIR,
  input  logic        i_loadPC,
  input  logic [15:0] i_K,
  input  logic [15:0] i_A,
  input  logic [15:0] i_Z,
  input  logic [15:0] i_PMDATA,
  output logic [15:0] o_IR,
  output logic [15:0] o_PMDATA,
  output logic [15:0] o_PMADDR
);

  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] ir_q, ir_d;
  logic [WORD_W-1:0] next_pc;

  ctrl_fetch_next_pc u_next_pc (
    .mode12k_i  (i_mode12K),
    .mode_src_i (i_modeAddZA),
    .pc_i       (pc_q),
    .k_i        (i_K),
    .a_i        (i_A),
    .z_i        (i_Z),
    .next_pc_o  (next_pc)
  );

  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    if (i_loadPC) pc_d = next_pc;
    if (i_loadIR) ir_d = i_PMDATA;
  end

  // Reset wins over any load strobe that happens to be high.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc_q <= '0;
      ir_q <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end

  assign o_IR     = ir_q;
  assign o_PMDATA = i_A;
  assign o_PMADDR = i_modePCZ ? i_Z : pc_q;

endmodule

// File: tb/tb_ctrl_fetch.sv
// tb/tb_ctrl_fetch.sv - self-checking bench for ctrl_fetch
module tb_ctrl_fetch;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [1:0]  i_mode12K = '0;
  logic [1:0]  i_modeAddZA = '0;
  logic        i_modePCZ = 1'b0;
  logic        i_loadIR = 1'b0;
  logic        i_loadPC = 1'b0;
  logic [15:0] i_K = '0;
  logic [15:0] i_A = '0;
  logic [15:0] i_Z = '0;
  logic [15:0] i_PMDATA = '0;
  logic [15:0] o_IR;
  logic [15:0] o_PMDATA;
  logic [15:0] o_PMADDR;

  ctrl_fetch dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_mode12K   (i_mode12K),
    .i_modeAddZA (i_modeAddZA),
    .i_modePCZ   (i_modePCZ),
    .i_loadIR    (i_loadIR),
    .i_loadPC    (i_loadPC),
    .i_K         (i_K),
    .i_A         (i_A),
    .i_Z         (i_Z),
    .i_PMDATA    (i_PMDATA),
    .o_IR        (o_IR),
    .o_PMDATA    (o_PMDATA),
    .o_PMADDR    (o_PMADDR)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        ld_pc;
    logic        ld_ir;
    logic [1:0]  m12;
    logic [1:0]  mza;
    logic        pcz;
    logic [15:0] k;
    logic [15:0] a;
    logic [15:0] z;
    logic [15:0] pm;
    logic [15:0] exp_ir;
    logic [15:0] exp_addr;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   pc_m, ir_m;

  function automatic vec_t mk(input logic ld_pc, input logic ld_ir,
                              input logic [1:0] m12, input logic [1:0] mza,
                              input logic pcz, input logic [15:0] k,
                              input logic [15:0] a, input logic [15:0] z,
                              input logic [15:0] pm, input logic [15:0] exp_ir,
                              input logic [15:0] exp_addr);
    vec_t v;
    v.ld_pc = ld_pc; v.ld_ir = ld_ir; v.m12 = m12; v.mza = mza; v.pcz = pcz;
    v.k = k; v.a = a; v.z = z; v.pm = pm; v.exp_ir = exp_ir; v.exp_addr = exp_addr;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference next-PC from the arithmetic rules: signed integer offset, mod 65536.
  function automatic int ref_next(input int pc, input int m12, input int mza,
                                  input int k, input int a, input int z);
    int off;
    case (m12)
      0: off = 1;
      1: off = 2;
      2: begin
        off = k % 4096;
        if (off >= 2048) off = off - 4096;
      end
      default: off = k;
    endcase
    case (mza)
      0: return (pc + off) & 32'hFFFF;
      1: return off & 32'hFFFF;
      2: return z;
      default: return a;
    endcase
  endfunction

  initial begin
    // Reset state, before any clock edge
    #1 i_reset = 1'b1;
    #1;
    check("reset_ir", o_IR, 16'h0000);
    check("reset_addr", o_PMADDR, 16'h0000);
    @(negedge i_clk);
    i_reset = 1'b0;

    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 16'(i), 16'h0000, 16'h0000));
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mk(0, 1, 2'd0, 2'd0, 0, 0, 0, 0, 16'(8 + i), 16'(8 + i), 16'h0000));
      vecs.push_back(mk(0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 16'hFFFF, 16'(8 + i), 16'h0000));
    end
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 2'd0, 2'd0, 1, 0, 0, 16'(i), 0, 16'h000C, 16'(i)));
    vecs.push_back(mk(0, 0, 2'd0, 2'd0, 0, 0, 0, 16'h0003, 0, 16'h000C, 16'h0000));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 0, 2'd0, 2'd2, 0, 0, 0, 16'(i), 0, 16'h000C, 16'(i)));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 0, 2'd0, 2'd3, 0, 0, 16'(i), 0, 0, 16'h000C, 16'(i)));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 16'h000C, 16'h0004));
    vecs.push_back(mk(1, 0, 2'd1, 2'd0, 0, 0, 0, 0, 0, 16'h000C, 16'h0006));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 16'h000C, 16'h0007));
    vecs.push_back(mk(1, 0, 2'd1, 2'd0, 0, 0, 0, 0, 0, 16'h000C, 16'h0009));
    vecs.push_back(mk(1, 0, 2'd0, 2'd1, 0, 0, 0, 0, 0, 16'h000C, 16'h0001));
    vecs.push_back(mk(1, 0, 2'd1, 2'd1, 0, 0, 0, 0, 0, 16'h000C, 16'h0002));
    vecs.push_back(mk(1, 0, 2'd0, 2'd1, 0, 0, 0, 0, 0, 16'h000C, 16'h0001));
    vecs.push_back(mk(1, 0, 2'd1, 2'd1, 0, 0, 0, 0, 0, 16'h000C, 16'h0002));
    vecs.push_back(mk(1, 0, 2'd0, 2'd2, 0, 0, 0, 16'h0010, 0, 16'h000C, 16'h0010));
    vecs.push_back(mk(1, 0, 2'd2, 2'd0, 0, 16'h0FFC, 0, 0, 0, 16'h000C, 16'h000C));
    vecs.push_back(mk(1, 0, 2'd3, 2'd0, 0, 16'h0008, 0, 0, 0, 16'h000C, 16'h0014));
    vecs.push_back(mk(1, 0, 2'd0, 2'd2, 0, 0, 0, 16'hFFFF, 0, 16'h000C, 16'hFFFF));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 16'h000C, 16'h0000));
    vecs.push_back(mk(1, 0, 2'd2, 2'd0, 0, 16'hF7FF, 0, 0, 0, 16'h000C, 16'h07FF));
    vecs.push_back(mk(1, 0, 2'd2, 2'd1, 0, 16'h0800, 0, 0, 0, 16'h000C, 16'hF800));
    vecs.push_back(mk(1, 0, 2'd3, 2'd1, 0, 16'hABCD, 0, 0, 0, 16'h000C, 16'hABCD));
    vecs.push_back(mk(1, 1, 2'd0, 2'd3, 0, 0, 16'h1234, 0, 16'hBEEF, 16'hBEEF, 16'h1234));

    foreach (vecs[i]) begin
      i_loadPC = vecs[i].ld_pc; i_loadIR = vecs[i].ld_ir;
      i_mode12K = vecs[i].m12; i_modeAddZA = vecs[i].mza; i_modePCZ = vecs[i].pcz;
      i_K = vecs[i].k; i_A = vecs[i].a; i_Z = vecs[i].z; i_PMDATA = vecs[i].pm;
      @(posedge i_clk);
      #1;
      check($sformatf("vec%0d_ir", i), o_IR, vecs[i].exp_ir);
      check($sformatf("vec%0d_addr", i), o_PMADDR, vecs[i].exp_addr);
      check($sformatf("vec%0d_pmdata", i), o_PMDATA, vecs[i].a);
    end

    // Zero-latency Z path with no clock edge in between
    i_loadPC = 0; i_loadIR = 0;
    i_modePCZ = 1; i_Z = 16'h7E57;
    #1 check("zpath_a", o_PMADDR, 16'h7E57);
    i_Z = 16'h0102;
    #1 check("zpath_b", o_PMADDR, 16'h0102);
    i_modePCZ = 0;
    #1 check("zpath_back_pc", o_PMADDR, 16'h1234);

    // Async reset mid-cycle with both loads pending
    i_loadPC = 1; i_loadIR = 1; i_modeAddZA = 2'd3; i_A = 16'h5555; i_PMDATA = 16'hAAAA;
    @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    check("async_rst_ir", o_IR, 16'h0000);
    check("async_rst_pc", o_PMADDR, 16'h0000);
    @(posedge i_clk);
    #1;
    check("rst_hold_ir", o_IR, 16'h0000);
    check("rst_hold_pc", o_PMADDR, 16'h0000);
    @(negedge i_clk);
    i_loadPC = 0; i_loadIR = 0;
    i_reset = 1'b0;

    // Randomized run against the reference model
    pc_m = 0; ir_m = 0;
    for (int n = 0; n < 400; n++) begin
      i_reset     = ($urandom_range(0, 39) == 0);
      i_loadPC    = 1'($urandom_range(0, 1));
      i_loadIR    = 1'($urandom_range(0, 1));
      i_mode12K   = 2'($urandom_range(0, 3));
      i_modeAddZA = 2'($urandom_range(0, 3));
      i_modePCZ   = ($urandom_range(0, 3) == 0);
      i_K         = 16'($urandom);
      i_A         = 16'($urandom);
      i_Z         = 16'($urandom);
      i_PMDATA    = 16'($urandom);
      if (i_reset) begin
        pc_m = 0; ir_m = 0;
      end
      #1;
      check("rnd_ir", o_IR, 16'(ir_m));
      check("rnd_addr", o_PMADDR, i_modePCZ ? i_Z : 16'(pc_m));
      check("rnd_pmdata", o_PMDATA, i_A);
      if (!i_reset) begin
        if (i_loadPC) pc_m = ref_next(pc_m, int'(i_mode12K), int'(i_modeAddZA),
                                      int'(i_K), int'(i_A), int'(i_Z));
        if (i_loadIR) ir_m = int'(i_PMDATA);
      end
      @(posedge i_clk);
      #1;
    end
    i_reset = 0; i_loadPC = 0; i_loadIR = 0; i_modePCZ = 0;
    #1;
    check("final_ir", o_IR, 16'(ir_m));
    check("final_pc", o_PMADDR, 16'(pc_m));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ctrl_fetch.md
Name: ctrl_fetch

Overview:
- Instruction-fetch control block of the core's control unit.
- Holds the program counter (PC) and instruction register (IR).
- Computes the next PC from a selectable base and offset, and drives the program-memory address and write-data buses.
- Sits between the sequencer, which drives the mode and load strobes, and program memory (PM).

Parameters:
- none (all datapaths fixed at 16 bits)

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_mode12K  in  2  offset select: 00 → +1, 01 → +2, 10 → sign-extended K[11:0], 11 → K[15:0]
- i_modeAddZA  in  2  next-PC source: 00 → PC+offset, 01 → offset (absolute), 10 → Z, 11 → A
- i_modePCZ  in  1  PM address select: 0 → PC, 1 → Z
- i_loadIR  in  1  load IR from i_PMDATA
- i_loadPC  in  1  load PC with the computed next-PC value
- i_K  in  16  immediate/constant operand from the decoder
- i_A  in  16  register-file operand A
- i_Z  in  16  Z pointer
- i_PMDATA  in  16  program-memory read data
- o_IR  out  16  instruction register
- o_PMDATA  out  16  program-memory write data
- o_PMADDR  out  16  program-memory address

Behaviour:
- Reset (async, active-high): PC = 0x0000, IR = 0x0000. Outputs take their reset-derived values immediately, without waiting for a clock: o_PMADDR = 0x0000 when i_modePCZ = 0, o_IR = 0x0000.
- Reset has priority over all loads. Asserting reset mid-operation discards any pending load.
- Offset (combinational), selected by i_mode12K:
  - 00: 0x0001
  - 01: 0x0002
  - 10: {{4{K[11]}}, K[11:0]}
  - 11: K
- Next PC (combinational), selected by i_modeAddZA:
  - 00: PC + offset
  - 01: offset
  - 10: Z (offset ignored)
  - 11: A (offset ignored)
- All additions are 16-bit modulo 2^16. Wrap-around is silent; there is no carry out.
- PC register: on a rising edge with i_loadPC = 1, PC ← next PC. Otherwise PC holds. The update is visible one cycle later.
- IR register: on a rising edge with i_loadIR = 1, IR ← i_PMDATA. Otherwise IR holds. o_IR = IR.
- i_loadPC and i_loadIR are independent. Both may be asserted in the same cycle, and both registers then update on that edge.
- o_PMADDR is combinational, zero latency: Z when i_modePCZ = 1, else PC. A change on i_Z propagates immediately while i_modePCZ = 1.
- o_PMDATA is combinational: o_PMDATA = i_A.
- The block has no handshake and no stall input. The sequencer owns all timing.

Decomposition:
- Shared control package holds the encodings for i_mode12K (OFF_1, OFF_2, OFF_K12, OFF_K16) and i_modeAddZA (SRC_PC, SRC_ABS, SRC_Z, SRC_A), plus a WORD_W = 16 constant.
- One natural sub-module, ctrl_fetch_next_pc: purely combinational offset mux, adder and source mux. The PC and IR registers and the address mux stay in ctrl_fetch.

Test Plan:
- Reset, then hold all loads low while i_PMDATA steps 0..4: o_IR stays 0x0000 and o_PMADDR stays 0x0000. Then pulse i_loadIR with i_PMDATA = 0x0008, 0x0009, 0x000A, 0x000B, 0x000C: o_IR follows each value one edge after its pulse and holds between pulses.
- Set i_modePCZ = 1 and step i_Z 0..3: o_PMADDR = 0, 1, 2, 3 in the same cycle. Return i_modePCZ to 0: o_PMADDR = PC = 0x0000.
- i_modeAddZA = 10, pulse i_loadPC with i_Z = 0..3: PC, visible on o_PMADDR, becomes 0, 1, 2, 3. Repeat with i_modeAddZA = 11 and i_A = 0..3: same results.
- i_modeAddZA = 00, PC = 3, pulse i_loadPC with i_mode12K = 00, 01, 00, 01: PC = 4, 6, 7, 9. Then i_modeAddZA = 01 with the same pulses: PC = 1, 2, 1, 2.
- i_modeAddZA = 00, i_mode12K = 10, PC = 0x0010, i_K = 0x0FFC: PC becomes 0x000C (sign extension). With i_mode12K = 11 and i_K = 0x0008: PC becomes 0x0014. PC = 0xFFFF with i_mode12K = 00: PC wraps to 0x0000.
- Assert i_reset asynchronously mid-cycle with i_loadPC = i_loadIR = 1: PC and IR clear immediately, and no load occurs on the following edge while reset is high.
